fb_port_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between display scan-out and CPU writes.

---
 rtl/fb_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_fb_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer RAM between
// display scan-out (absolute priority) and buffered CPU writes.
//
// Ports:
//   clk_pix, rst_pix_n       pixel clock, synchronous active-low reset
//   sx, sy                   beam position from the timing generator
//   cpu_wr_valid/ready       CPU write handshake (addr, data)
//   mem_addr/we/wdata/rdata  single-port synchronous RAM port
//   pix_data, pix_valid      scanned-out pixel, 2 cycles after sx/sy
//   fifo_level               CPU write FIFO occupancy
//   frame_start              registered pulse at sx==0 && sy==0
module fb_port_arbiter #(
    parameter int WIDTH      = 10,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_pix,
    input  logic                          rst_pix_n,
    input  logic [WIDTH-1:0]              sx,
    input  logic [WIDTH-1:0]              sy,
    input  logic                          cpu_wr_valid,
    input  logic [ADDR_W-1:0]             cpu_wr_addr,
    input  logic [DATA_W-1:0]             cpu_wr_data,
    output logic                          cpu_wr_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [DATA_W-1:0]             pix_data,
    output logic                          pix_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_start
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [WIDTH-1:0] H_LIM = WIDTH'(H_RES);
    localparam logic [WIDTH-1:0] V_LIM = WIDTH'(V_RES);
    localparam logic [LVL_W-1:0] FULL  = LVL_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    wr_t               head;

    logic [ADDR_W-1:0] scan_q;
    logic [ADDR_W-1:0] scan_addr;
    logic              disp_rd;
    logic              origin;
    logic              push;
    logic              pop;
    logic [1:0]        vld_pipe;

    assign disp_rd   = (sx < H_LIM) && (sy < V_LIM);
    assign origin    = (sx == '0) && (sy == '0);

    // The origin cycle itself reads address 0, whatever the
    // counter held from the previous frame (or a mid-frame reset).
    assign scan_addr = origin ? '0 : scan_q;

    assign cpu_wr_ready = (fifo_level < FULL);
    assign push         = cpu_wr_valid && cpu_wr_ready;

    // Pop decision uses the registered level, so an entry pushed
    // into an empty FIFO drains no earlier than the next cycle.
    assign pop          = !disp_rd && (fifo_level != '0);
    assign head         = fifo_mem[rd_ptr];

    assign pix_valid = vld_pipe[1];
    assign pix_data  = pix_valid ? mem_rdata : '0;

    // Storage needs no reset: the pointers define what is live.
    always_ff @(posedge clk_pix) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: cpu_wr_addr,
                                  data: cpu_wr_data};
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            scan_q      <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            vld_pipe    <= '0;
            frame_start <= 1'b0;
        end else begin
            if (disp_rd) begin
                scan_q <= scan_addr + ADDR_W'(1);
            end else begin
                scan_q <= scan_addr;
            end

            unique case (1'b1)
                disp_rd: begin
                    mem_addr <= scan_addr;
                    mem_we   <= 1'b0;
                end
                pop: begin
                    mem_addr  <= head.addr;
                    mem_wdata <= head.data;
                    mem_we    <= 1'b1;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase

            vld_pipe    <= {vld_pipe[0], disp_rd};
            frame_start <= origin;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: randomized CPU write traffic over a small
// raster, compared against a queue/array reference model.
module tb_fb_port_arbiter;

    localparam int W  = 10;
    localparam int H  = 16;
    localparam int V  = 8;
    localparam int HT = 20;
    localparam int VT = 10;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;
    localparam int NCYC = 3200;

    logic          clk_pix = 1'b0;
    logic          rst_pix_n = 1'b0;
    logic [W-1:0]  sx = '0;
    logic [W-1:0]  sy = '0;
    logic          cpu_wr_valid = 1'b0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic          cpu_wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic [LW-1:0] fifo_level;
    logic          frame_start;

    always #5 clk_pix = ~clk_pix;

    fb_port_arbiter #(
        .WIDTH(W), .H_RES(H), .V_RES(V),
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)
    ) dut (
        .clk_pix(clk_pix),
        .rst_pix_n(rst_pix_n),
        .sx(sx),
        .sy(sy),
        .cpu_wr_valid(cpu_wr_valid),
        .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_data(cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .fifo_level(fifo_level),
        .frame_start(frame_start)
    );

    // Single-port synchronous RAM, preloaded with RAM[a] = a[7:0].
    logic [DW-1:0] ram [2**AW];
    logic          ram_init = 1'b1;

    always @(posedge clk_pix) begin
        if (ram_init) begin
            for (int i = 0; i < 2**AW; i++) ram[i] <= DW'(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           q[$];
    logic [DW-1:0] gold [2**AW];

    bit            known, synced, hold;
    bit            e_we, e_ac, e_rz, e_fs;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit            p1v, p2v, p1k, p2k;
    logic [DW-1:0] p1d, p2d;

    int hx, vy, prob, frame, rst_left;
    bit did_mid;

    initial begin
        for (int i = 0; i < 2**AW; i++) gold[i] = DW'(i);
        known = 0; synced = 0; hold = 0;
        e_we = 0; e_ac = 0; e_rz = 0; e_fs = 0;
        e_addr = '0; e_data = '0;
        p1v = 0; p2v = 0; p1k = 0; p2k = 0;
        p1d = '0; p2d = '0;
        hx = 5; vy = 3; prob = 60; frame = 0;
        rst_left = 3; did_mid = 0;

        @(posedge clk_pix);
        #1;
        ram_init = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            bit disp, org, acc;
            int occ, a;
            wr_t w;

            org = (hx == 0) && (vy == 0);
            if (org) begin
                frame++;
                prob = (frame == 6) ? 100 : $urandom_range(5, 95);
            end
            if (!did_mid && frame == 6 && vy == 5 && hx == 3) begin
                did_mid  = 1;
                rst_left = 2;
            end

            rst_pix_n = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            sx = W'(hx);
            sy = W'(vy);
            if (cyc < 3) begin
                cpu_wr_valid = 1'b1;
            end else if (!hold) begin
                cpu_wr_valid = ($urandom_range(0, 99) < prob);
                cpu_wr_addr  = AW'($urandom);
                cpu_wr_data  = DW'($urandom);
            end

            @(negedge clk_pix);

            if (known) begin
                check("ready", 32'(cpu_wr_ready), 32'(q.size() < D));
                check("level", 32'(fifo_level), 32'(q.size()));
                check("mem_we", 32'(mem_we), 32'(e_we));
                if (e_we) begin
                    check("wr_addr", 32'(mem_addr), 32'(e_addr));
                    check("wr_data", 32'(mem_wdata), 32'(e_data));
                end
                if (e_ac) check("rd_addr", 32'(mem_addr), 32'(e_addr));
                if (e_rz) check("wdata_rst", 32'(mem_wdata), 32'd0);
                check("pix_valid", 32'(pix_valid), 32'(p2v));
                if (!p2v) check("pix_zero", 32'(pix_data), 32'd0);
                else if (p2k) check("pix_data", 32'(pix_data), 32'(p2d));
                check("frame_start", 32'(frame_start), 32'(e_fs));
            end

            if (!rst_pix_n) begin
                q.delete();
                e_we = 0; e_ac = 1; e_rz = 1; e_fs = 0;
                e_addr = '0;
                p1v = 0; p2v = 0; p1k = 0; p2k = 0;
                synced = 0; known = 1; hold = 0;
            end else begin
                disp = (hx < H) && (vy < V);
                occ  = q.size();
                acc  = cpu_wr_valid && (occ < D);
                if (org) synced = 1;
                e_rz = 0;
                e_fs = org;
                p2v = p1v; p2d = p1d; p2k = p1k;
                p1v = disp; p1k = synced;
                if (disp) begin
                    a      = vy * H + hx;
                    e_we   = 0;
                    e_ac   = synced;
                    e_addr = AW'(a);
                    p1d    = gold[a];
                end else if (occ > 0) begin
                    w       = q.pop_front();
                    gold[w.a] = w.d;
                    e_we   = 1;
                    e_ac   = 0;
                    e_addr = w.a;
                    e_data = w.d;
                end else begin
                    e_we = 0;
                    e_ac = 0;
                end
                if (acc) begin
                    w.a = cpu_wr_addr;
                    w.d = cpu_wr_data;
                    q.push_back(w);
                end
                hold = cpu_wr_valid && !acc;
            end

            hx++;
            if (hx == HT) begin
                hx = 0;
                vy = (vy == VT - 1) ? 0 : vy + 1;
            end

            @(posedge clk_pix);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
